acond_entradas: RTL and testbench

ACOND_ENTRADAS -- requirements
Module: acond_entradas

---
 rtl/acond_entradas.sv | 90 +++++++++
 tb/tb_acond_entradas.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/acond_entradas.sv
// acond_entradas: synchronizes, debounces and hands off coin/select pin codes as single pending events.
// Define CONTADOR_MONEDAS_EN to add the saturating coin_cnt output.
module acond_canal #(parameter int DEB_CICLOS = 16) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pin,
  input  logic       ack,
  output logic [1:0] code,
  output logic       vld,
  output logic       evt
);
  localparam logic [1:0] IDLE = 2'd0, FILTRO = 2'd1, VALIDO = 2'd2, SUELTA = 2'd3;
  localparam logic [7:0] FIN_FILTRO = 8'(DEB_CICLOS - 2);
  localparam logic [7:0] FIN_SUELTA = 8'(DEB_CICLOS - 1);
  logic [1:0] s1, s2, cand, state;
  logic [7:0] cnt;
  assign evt = state == VALIDO;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      cand  <= '0;
      state <= IDLE;
      cnt   <= '0;
      code  <= '0;
      vld   <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      // a fresh event may replace the pending one only when it is acknowledged in the same cycle
      if (evt && (!vld || ack)) begin
        code <= cand;
        vld  <= 1'b1;
      end else if (ack) vld <= 1'b0;
      case (state)
        IDLE: if (s2 != 2'b00) begin
          cand  <= s2;
          cnt   <= '0;
          state <= FILTRO;
        end
        FILTRO: if (s2 != cand) state <= IDLE;
        else begin
          cnt <= cnt + 8'd1;
          if (cnt == FIN_FILTRO) state <= VALIDO;
        end
        VALIDO: begin
          cnt   <= '0;
          state <= SUELTA;
        end
        default: if (s2 != 2'b00) cnt <= '0;
        else if (cnt == FIN_SUELTA) state <= IDLE;
        else cnt <= cnt + 8'd1;
      endcase
    end
endmodule

module acond_entradas #(parameter int DEB_CICLOS = 16) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] moneda_in,
  input  logic [1:0] sel_in,
  input  logic       moneda_ack,
  input  logic       sel_ack,
  output logic [1:0] moneda_out,
  output logic       moneda_vld,
  output logic [1:0] sel_out,
  output logic       sel_vld,
`ifdef CONTADOR_MONEDAS_EN
  output logic [7:0] coin_cnt,
`endif
  output logic       err
);
  logic evt_m, evt_s;
  acond_canal #(.DEB_CICLOS(DEB_CICLOS)) u_moneda (
    .clk(clk), .rst(rst), .pin(moneda_in), .ack(moneda_ack),
    .code(moneda_out), .vld(moneda_vld), .evt(evt_m)
  );
  acond_canal #(.DEB_CICLOS(DEB_CICLOS)) u_sel (
    .clk(clk), .rst(rst), .pin(sel_in), .ack(sel_ack),
    .code(sel_out), .vld(sel_vld), .evt(evt_s)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else err <= (evt_m && moneda_vld && !moneda_ack) || (evt_s && sel_vld && !sel_ack);
`ifdef CONTADOR_MONEDAS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) coin_cnt <= '0;
    else if (evt_m && (!moneda_vld || moneda_ack) && coin_cnt != 8'hff) coin_cnt <= coin_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_acond_entradas.sv
// tb_acond_entradas: random and directed stimulus checked against a timestamp-based event model.
module tb_acond_entradas;
  localparam int DEB = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] moneda_in = '0, sel_in = '0;
  logic moneda_ack = 1'b0, sel_ack = 1'b0;
  logic [1:0] moneda_out, sel_out;
  logic moneda_vld, sel_vld, err;
`ifdef CONTADOR_MONEDAS_EN
  logic [7:0] coin_cnt;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  acond_entradas #(.DEB_CICLOS(DEB)) dut (
    .clk(clk), .rst(rst), .moneda_in(moneda_in), .sel_in(sel_in),
    .moneda_ack(moneda_ack), .sel_ack(sel_ack),
    .moneda_out(moneda_out), .moneda_vld(moneda_vld),
    .sel_out(sel_out), .sel_vld(sel_vld),
`ifdef CONTADOR_MONEDAS_EN
    .coin_cnt(coin_cnt),
`endif
    .err(err)
  );

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // Model: pin seen two edges late; an event fires after DEB equal nonzero samples,
  // then the channel is deaf until DEB zero samples follow the last nonzero one.
  logic [1:0] h1[2], h2[2], cand[2], m_out[2], pin_s[2];
  int ts[2], fire[2], lnz[2], t, m_cnt;
  bit quiet[2], m_vld[2], ak[2], m_err, drop;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; m_err = 0; m_cnt = 0;
      for (int c = 0; c < 2; c++) begin
        h1[c] = 0; h2[c] = 0; cand[c] = 0; m_out[c] = 0; ts[c] = 0;
        fire[c] = -1; lnz[c] = 0; quiet[c] = 0; m_vld[c] = 0;
      end
    end else begin
      t++;
      drop = 0;
      pin_s[0] = moneda_in; pin_s[1] = sel_in;
      ak[0] = moneda_ack; ak[1] = sel_ack;
      for (int c = 0; c < 2; c++) begin
        if (fire[c] == t) begin
          if (!m_vld[c] || ak[c]) begin
            m_out[c] = cand[c];
            m_vld[c] = 1;
            if (c == 0 && m_cnt < 255) m_cnt++;
          end else drop = 1;
        end else if (ak[c]) m_vld[c] = 0;
        if (fire[c] != t) begin
          if (quiet[c]) begin
            if (h2[c] != 0) lnz[c] = t;
            else if (t - lnz[c] == DEB) begin quiet[c] = 0; cand[c] = 0; end
          end else if (cand[c] == 0) begin
            if (h2[c] != 0) begin cand[c] = h2[c]; ts[c] = t; end
          end else if (h2[c] != cand[c]) cand[c] = 0;
          else if (t - ts[c] == DEB - 1) begin fire[c] = t + 1; quiet[c] = 1; lnz[c] = t + 1; end
        end
        h2[c] = h1[c];
        h1[c] = pin_s[c];
      end
      m_err = drop;
    end
  end

  always @(negedge clk) begin
    chk("moneda_out", moneda_out, m_out[0]);
    chk("moneda_vld", moneda_vld, m_vld[0]);
    chk("sel_out", sel_out, m_out[1]);
    chk("sel_vld", sel_vld, m_vld[1]);
    chk("err", err, m_err);
`ifdef CONTADOR_MONEDAS_EN
    chk("coin_cnt", coin_cnt, m_cnt);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_coin();
    moneda_ack = 1; cyc(1); moneda_ack = 0;
  endtask

  int seen, hm, hs;
  initial begin
    #1 rst = 1;
    cyc(3);
    chk("rst_moneda_vld", moneda_vld, 0);
    chk("rst_sel_vld", sel_vld, 0);
    chk("rst_moneda_out", moneda_out, 0);
    chk("rst_err", err, 0);
    rst = 0;
    cyc(2);
    // clean step: vld after DEB+3 edges
    moneda_in = 2'b10;
    repeat (6) @(posedge clk);
    #1 chk("lat_pre", moneda_vld, 0);
    @(posedge clk);
    #1 chk("lat_vld", moneda_vld, 1);
    chk("lat_out", moneda_out, 2);
    cyc(4);
    ack_coin();
    chk("lat_ack", moneda_vld, 0);
    seen = 0;
    repeat (8) begin cyc(1); seen |= moneda_vld; end
    moneda_in = 0;
    repeat (20) begin cyc(1); seen |= moneda_vld; end
    chk("single_event", seen, 0);
    // short glitch rejected
    moneda_in = 2'b01; cyc(3); moneda_in = 0;
    seen = 0;
    repeat (15) begin cyc(1); seen |= moneda_vld | err; end
    chk("glitch", seen, 0);
    // second coin dropped while first pending
    moneda_in = 2'b11; cyc(8); moneda_in = 0; cyc(10);
    chk("pend_out", moneda_out, 3);
    moneda_in = 2'b01;
    seen = 0;
    repeat (8) begin cyc(1); seen += int'(err); end
    moneda_in = 0;
    repeat (10) begin cyc(1); seen += int'(err); end
    chk("drop_pulses", seen, 1);
    chk("drop_keep_out", moneda_out, 3);
    chk("drop_keep_vld", moneda_vld, 1);
    moneda_ack = 1;
    @(posedge clk);
    #1 chk("drop_ack_clear", moneda_vld, 0);
    @(negedge clk) moneda_ack = 0;
    // ack coincident with reload
    moneda_in = 2'b01; cyc(8); moneda_in = 0; cyc(10);
    chk("reload_pre", moneda_out, 1);
    moneda_in = 2'b10;
    repeat (6) @(posedge clk);
    @(negedge clk) moneda_ack = 1;
    @(posedge clk);
    #1 chk("reload_vld", moneda_vld, 1);
    chk("reload_out", moneda_out, 2);
    @(negedge clk) moneda_ack = 0;
    chk("reload_err", err, 0);
    cyc(2); moneda_in = 0; cyc(10);
    ack_coin();
    // async reset with FILTRO in progress and select pending
    sel_in = 2'b01; cyc(8); sel_in = 0; cyc(10);
    chk("sel_pend", sel_vld, 1);
    moneda_in = 2'b11;
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1 chk("arst_sel_vld", sel_vld, 0);
    chk("arst_sel_out", sel_out, 0);
    chk("arst_moneda_out", moneda_out, 0);
    moneda_in = 0;
    cyc(3); rst = 0;
    seen = 0;
    repeat (20) begin cyc(1); seen |= moneda_vld | sel_vld; end
    chk("arst_no_event", seen, 0);
    // input held through reset is a new event after full latency
    #2 rst = 1;
    moneda_in = 2'b10;
    cyc(3); rst = 0;
    repeat (6) @(posedge clk);
    #1 chk("post_rst_pre", moneda_vld, 0);
    @(posedge clk);
    #1 chk("post_rst_vld", moneda_vld, 1);
    @(negedge clk) moneda_in = 0;
    cyc(12);
    ack_coin();
    // random traffic on both channels
    hm = 0; hs = 0;
    repeat (1500) begin
      @(negedge clk);
      if (hm == 0) begin moneda_in = 2'($urandom_range(0, 3)); hm = int'($urandom_range(1, 3 * DEB)); end
      else hm--;
      if (hs == 0) begin sel_in = 2'($urandom_range(0, 3)); hs = int'($urandom_range(1, 3 * DEB)); end
      else hs--;
      moneda_ack = $urandom_range(0, 3) == 0;
      sel_ack = $urandom_range(0, 3) == 0;
    end
    moneda_in = 0; sel_in = 0; moneda_ack = 0; sel_ack = 0;
    cyc(12);
`ifdef CONTADOR_MONEDAS_EN
    #2 rst = 1;
    cyc(2); rst = 0;
    moneda_ack = 1;
    repeat (260) begin
      moneda_in = 2'b01; cyc(6); moneda_in = 0; cyc(8);
    end
    cyc(4);
    chk("coin_cnt_sat", coin_cnt, 255);
    moneda_ack = 0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
